// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: program counter, combinational imem address and IF/ID register.
// Optional FETCH_BOUNDS_CHECK_EN adds a sticky fetch_fault output for fetches beyond IMEM_WORDS.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
`ifdef FETCH_BOUNDS_CHECK_EN
  output logic        if_id_valid,
  output logic        fetch_fault
`else
  output logic        if_id_valid
`endif
);

  logic [31:0] pc_plus4;
  logic        discard;
  logic        capture;

  // A zero-depth memory makes every fetch meaningless, so refuse to elaborate.
  if (IMEM_WORDS <= 0) begin : g_bad_depth
    $error("instruction_fetch_unit: IMEM_WORDS must be positive");
  end

  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign discard   = flush || redirect;
  assign capture   = !discard && !stall;

`ifdef FETCH_BOUNDS_CHECK_EN
  logic out_of_range;
  assign out_of_range = {2'b00, pc[31:2]} >= 32'(IMEM_WORDS);
`endif

  // Redirect wins over stall; the target is forced to a word boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_target & 32'hFFFF_FFFC;
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

  // Flush or redirect throws away the wrong-path word even while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
    end else if (discard) begin
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
    end else if (capture && out_of_range) begin
      if_id_instr    <= NOP_WORD;
      if_id_pc_plus4 <= 32'd0;
      if_id_valid    <= 1'b0;
`endif
    end else if (capture) begin
      if_id_instr    <= imem_data;
      if_id_pc_plus4 <= pc_plus4;
      if_id_valid    <= 1'b1;
    end
  end

`ifdef FETCH_BOUNDS_CHECK_EN
  // Sticky until reset so software can inspect it after the fact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_fault <= 1'b0;
    end else if (capture && out_of_range) begin
      fetch_fault <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit with a combinational 1024-word memory model.
// Exercises the FETCH_BOUNDS_CHECK_EN path when that macro is defined.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic        fetch_fault;
`endif

  logic [31:0] mem [0:1023];
  logic [31:0] prog [0:7];
  int          assertCount;
  int          failCount;

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .flush          (flush),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus4 (if_id_pc_plus4),
`ifdef FETCH_BOUNDS_CHECK_EN
    .if_id_valid    (if_id_valid),
    .fetch_fault    (fetch_fault)
`else
    .if_id_valid    (if_id_valid)
`endif
  );

  assign imem_data = mem[imem_addr[11:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%08h required=%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic r, input logic [31:0] t);
    stall           = s;
    flush           = f;
    redirect        = r;
    redirect_target = t;
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    prog[0] = 32'h02108020; prog[1] = 32'h02318820;
    prog[2] = 32'h02529020; prog[3] = 32'h02739820;
    prog[4] = 32'h0294a020; prog[5] = 32'h02b5a820;
    prog[6] = 32'h02d6b020; prog[7] = 32'h02f7b820;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    for (int i = 0; i < 8; i++) mem[i] = prog[i];
    mem[1023] = 32'hDEADBEEF;

    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    #2;
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_instr", if_id_instr, 32'h0);
    checkOutput("reset_pc4", if_id_pc_plus4, 32'h0);
    checkOutput("reset_valid", {31'b0, if_id_valid}, 32'h0);
    #1;
    reset = 1'b0;

    $display("[TB] straight-line fetch");
    for (int i = 0; i < 8; i++) begin
      checkOutput("seq_addr", imem_addr, 32'(4 * i));
      tick();
      checkOutput("seq_instr", if_id_instr, prog[i]);
      checkOutput("seq_pc4", if_id_pc_plus4, 32'(4 * (i + 1)));
      checkOutput("seq_valid", {31'b0, if_id_valid}, 32'h1);
    end

    $display("[TB] stall at pc=8");
    doReset();
    tick();
    tick();
    checkOutput("pre_stall_pc", pc, 32'h8);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("stall_pc", pc, 32'h8);
      checkOutput("stall_instr", if_id_instr, 32'h02318820);
      checkOutput("stall_pc4", if_id_pc_plus4, 32'h8);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("release_instr", if_id_instr, 32'h02529020);
    checkOutput("release_pc4", if_id_pc_plus4, 32'hC);
    checkOutput("release_pc", pc, 32'hC);

    $display("[TB] redirect to unaligned 0x13");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h13);
    tick();
    checkOutput("redir_pc", pc, 32'h10);
    checkOutput("redir_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("redir_instr", if_id_instr, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("post_redir_instr", if_id_instr, 32'h0294a020);
    checkOutput("post_redir_pc4", if_id_pc_plus4, 32'h14);
    checkOutput("post_redir_pc", pc, 32'h14);

    $display("[TB] asynchronous reset mid-cycle");
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_pc", pc, 32'h0);
    checkOutput("async_addr", imem_addr, 32'h0);
    checkOutput("async_instr", if_id_instr, 32'h0);
    checkOutput("async_valid", {31'b0, if_id_valid}, 32'h0);
    reset = 1'b0;
    tick();
    checkOutput("after_async_instr", if_id_instr, 32'h02108020);
    tick();
    checkOutput("pre_combo_pc", pc, 32'h8);

    $display("[TB] stall+flush+redirect and stall+flush");
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h4);
    tick();
    checkOutput("sfr_pc", pc, 32'h4);
    checkOutput("sfr_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("sfr_pc4", if_id_pc_plus4, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("refill_instr", if_id_instr, 32'h02318820);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("sf_pc", pc, 32'h8);
    checkOutput("sf_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("sf_instr", if_id_instr, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("sf_release_instr", if_id_instr, 32'h02529020);
    checkOutput("sf_release_pc4", if_id_pc_plus4, 32'hC);

    $display("[TB] PC wrap");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    tick();
    checkOutput("wrap_top_pc", pc, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("wrap_pc", pc, 32'h0);
    checkOutput("wrap_pc4", if_id_pc_plus4, 32'h0);
    checkOutput("wrap_instr", if_id_instr, 32'hDEADBEEF);
    checkOutput("wrap_valid", {31'b0, if_id_valid}, 32'h1);
    tick();
    checkOutput("post_wrap_instr", if_id_instr, 32'h02108020);
    checkOutput("post_wrap_pc4", if_id_pc_plus4, 32'h4);

    $display("[TB] fetch beyond memory depth");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h1000);
    tick();
    checkOutput("oob_pc", pc, 32'h1000);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("oob_next_pc", pc, 32'h1004);
`ifdef FETCH_BOUNDS_CHECK_EN
    checkOutput("oob_valid", {31'b0, if_id_valid}, 32'h0);
    checkOutput("oob_instr", if_id_instr, 32'h0);
    checkOutput("oob_fault", {31'b0, fetch_fault}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("fault_sticky_valid", {31'b0, if_id_valid}, 32'h1);
    checkOutput("fault_sticky", {31'b0, fetch_fault}, 32'h1);
    doReset();
    checkOutput("fault_cleared", {31'b0, fetch_fault}, 32'h0);
`else
    checkOutput("oob_valid", {31'b0, if_id_valid}, 32'h1);
    checkOutput("oob_instr", if_id_instr, 32'h02108020);
    checkOutput("oob_pc4", if_id_pc_plus4, 32'h1004);
`endif

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Initiator side of the instruction-memory read interface. Holds the program counter and drives the word-aligned fetch address to the combinational instruction memory. Captures the returned instruction into the IF/ID pipeline register. Handles hazard stalls, pipeline flushes and branch/jump redirects from later stages.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
IMEM_WORDS, 1024, instruction memory depth in 32-bit words (4 KB); used by the bounds check only
NOP_WORD, 32'h00000000, instruction word inserted as a bubble (sll $zero,$zero,0)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
imem_addr  output  32  byte address to instruction memory; always equals pc
imem_data  input  32  instruction word from memory, valid in the same cycle (combinational read)
stall  input  1  hazard unit: hold PC and IF/ID
flush  input  1  replace the IF/ID contents with a bubble
redirect  input  1  branch taken or jump: load redirect_target into PC
redirect_target  input  32  new PC byte address
pc  output  32  current program counter
if_id_instr  output  32  registered instruction to decode
if_id_pc_plus4  output  32  registered PC+4 of that instruction
if_id_valid  output  1  1 = if_id_instr is a real fetched instruction; 0 = bubble

Behaviour:
- Reset (asynchronous, any time, including mid-stall or mid-redirect): pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc_plus4=0, if_id_valid=0. Takes effect immediately; first fetch occurs at RESET_PC in the first cycle after reset deasserts.
- imem_addr = pc, combinational. Memory indexes by pc>>2.
- PC update on each rising edge, in priority order:
  1. redirect=1: pc <= {redirect_target[31:2],2'b00}. Low bits are forced to zero. Overrides stall.
  2. else stall=1: pc holds.
  3. else: pc <= pc+4, modulo 2^32. 32'hFFFFFFFC wraps to 0.
- IF/ID update on each rising edge, in priority order:
  1. flush=1 or redirect=1: instr=NOP_WORD, pc_plus4=0, valid=0. The wrong-path word fetched this cycle is discarded. Applies even when stall=1.
  2. else stall=1: all IF/ID fields hold.
  3. else: instr=imem_data, pc_plus4=pc+4, valid=1.
- Latency: an instruction at address A appears on if_id_instr one edge after pc=A, provided there is no stall, flush or redirect.
- Stall followed by release: no instruction is lost or duplicated. The held word is re-presented and then advances.
- No internal FSM beyond the PC/IF/ID registers; there are no handshake outputs.

Optional Feature:
FETCH_BOUNDS_CHECK_EN
- Defined: adds output fetch_fault (1 bit, reset 0).
  - On any non-stalled, non-flushed capture with pc>>2 >= IMEM_WORDS, IF/ID loads a bubble (NOP_WORD, valid=0) instead of imem_data.
  - fetch_fault sets and stays sticky until reset.
  - PC still advances normally.
- Undefined: no fetch_fault port. Out-of-range PCs are fetched without checking (memory index behaviour is the memory's own).

Test Plan:
- Reset, then run 8 cycles with the program 02108020, 02318820, 02529020, 02739820, 0294a020, 02b5a820, 02d6b020, 02f7b820 -> imem_addr steps 0,4,...,1C. if_id_instr equals each word one cycle later. if_id_pc_plus4 steps 4..20. valid=1 from cycle 1.
- Assert stall for 2 cycles while pc=8 -> pc holds 8. if_id holds 02318820/pc_plus4=8. After release, 02529020 is captured with no duplicate or skip.
- Assert redirect with target=0x00000013 at pc=0x0C -> next pc=0x10. if_id_valid=0 and if_id_instr=0 for that edge. The following edge captures 0294a020.
- Assert stall, flush and redirect together (target 0x4) -> pc=4, IF/ID bubble. Assert stall, flush and no redirect -> pc holds, IF/ID bubble.
- Force pc to 0xFFFFFFFC via redirect, then run free -> pc wraps to 0x00000000. if_id_pc_plus4=0x00000000 for the wrapping fetch.
- Pulse reset asynchronously mid-cycle while pc=0x14 -> outputs reset immediately without waiting for clk. With FETCH_BOUNDS_CHECK_EN, redirect to 0x1000 -> bubble captured, fetch_fault=1 and it stays 1 until reset.
